pkt_read_ctrl: RTL and testbench

Downstream readout stage of the ADC capture packet controller. Once the write side has filled the 32K-entry capture buffer and raised `wr_done`, this block reads the buffer from address 0 to the top. It issues the buffer reads, absorbs the one-cycle buffer read latency, and streams the samples out as fixed-length packets over a valid/ready interface. Each packet starts with a header word. Backpressure is handled through a small skid buffer.

---
 rtl/pktctrl_pkg.sv | 17 +
 rtl/rd_skid_fifo.sv | 36 +++
 rtl/pkt_read_ctrl.sv | 140 ++++++++++++++
 tb/tb_pkt_read_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pktctrl_pkg.sv
// Shared definitions for the capture packet controller: readout FSM encoding,
// packet header tag and default buffer/packet geometry.
package pktctrl_pkg;

    localparam int DEF_ADDR_W  = 15;
    localparam int DEF_PKT_LEN = 256;

    localparam logic [7:0] PKT_HDR_TAG = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        DONE
    } rd_state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry synchronous FIFO that parks returned buffer read data while the
// packet output is stalled.
module rd_skid_fifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic [1:0]  count
);

    logic [15:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= !wr_ptr;
            if (pop)  rd_ptr <= !rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/pkt_read_ctrl.sv
// Readout side of the capture packet controller: walks the capture buffer and
// streams it out as header-prefixed packets over valid/ready.
//
// state | meaning
// IDLE  | waiting for a filled buffer (wr_done) that has not been read yet
// HDR   | presenting the header word of the current packet
// DATA  | presenting buffer data words of the current packet
// DONE  | all packets delivered; waits for rf_capture_start
module pkt_read_ctrl
    import pktctrl_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int PKT_LEN = DEF_PKT_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rf_capture_start,
    input  logic              wr_done,
    output logic              ren,
    output logic [ADDR_W-1:0] raddr,
    input  logic [15:0]       rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [15:0]       m_data,
    output logic              m_sop,
    output logic              m_eop,
    output logic              rd_busy,
    output logic              rd_done
);

    localparam int WORD_W = $clog2(PKT_LEN);
    localparam int PKT_W  = ADDR_W - WORD_W;

    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [WORD_W-1:0] word_cnt;
    logic [PKT_W-1:0]  pkt_cnt;
    logic              inflight;
    logic              all_issued;

    logic [1:0]        fifo_count;
    logic [15:0]       fifo_head;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              data_pop;
    logic              last_word;
    logic              last_pkt;
    logic              credit_ok;

    assign fifo_empty = (fifo_count == 2'd0);
    assign last_word  = (word_cnt == WORD_W'(PKT_LEN - 1));
    assign last_pkt   = &pkt_cnt;
    assign data_pop   = m_valid && m_ready && (state == DATA) && !rf_capture_start;

    // Read data arriving into an empty FIFO bypasses it when consumed the same cycle.
    assign fifo_push  = inflight && !(fifo_empty && data_pop);
    assign fifo_pop   = data_pop && !fifo_empty;

    assign credit_ok  = ({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, data_pop});
    assign ren        = ((state == HDR) || (state == DATA)) && !all_issued
                        && !rf_capture_start && credit_ok;

    rd_skid_fifo u_skid (
        .clk   (clk),
        .rst   (rst),
        .flush (rf_capture_start),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (rdata),
        .dout  (fifo_head),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        m_valid   = 1'b0;
        m_data    = 16'h0000;
        m_sop     = 1'b0;
        m_eop     = 1'b0;
        rd_busy   = 1'b0;
        case (state)
            IDLE: begin
                if (wr_done && !rd_done) state_nxt = HDR;
            end
            HDR: begin
                rd_busy = 1'b1;
                m_valid = 1'b1;
                m_sop   = 1'b1;
                m_data  = {PKT_HDR_TAG, 8'(pkt_cnt)};
                if (m_ready) state_nxt = DATA;
            end
            DATA: begin
                rd_busy = 1'b1;
                m_valid = !fifo_empty || inflight;
                m_data  = fifo_empty ? rdata : fifo_head;
                m_eop   = last_word;
                if (m_valid && m_ready && last_word) state_nxt = last_pkt ? DONE : HDR;
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rf_capture_start) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst || rf_capture_start) begin
            raddr      <= '0;
            word_cnt   <= '0;
            pkt_cnt    <= '0;
            inflight   <= 1'b0;
            all_issued <= 1'b0;
            rd_done    <= 1'b0;
        end else begin
            inflight <= ren;
            if (ren) begin
                raddr <= raddr + 1'b1;
                if (&raddr) all_issued <= 1'b1;
            end
            if (data_pop) begin
                word_cnt <= word_cnt + 1'b1;
                if (last_word) begin
                    if (last_pkt) rd_done <= 1'b1;
                    else          pkt_cnt <= pkt_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pkt_read_ctrl.sv
// Randomized bench for pkt_read_ctrl: a word-index stream model predicts every
// transferred word; stalls, aborts and resets are injected around it.
module tb_pkt_read_ctrl;
    import pktctrl_pkg::*;

    localparam int ADDR_W    = DEF_ADDR_W;
    localparam int PKT_LEN   = DEF_PKT_LEN;
    localparam int NPKT      = (1 << ADDR_W) / PKT_LEN;
    localparam int PKT_WORDS = PKT_LEN + 1;
    localparam int TOTAL     = NPKT * PKT_WORDS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rf_capture_start = 1'b0;
    logic              wr_done = 1'b0;
    logic              m_ready = 1'b0;
    logic              ren;
    logic [ADDR_W-1:0] raddr;
    logic [15:0]       rdata = 16'h0000;
    logic              m_valid;
    logic [15:0]       m_data;
    logic              m_sop;
    logic              m_eop;
    logic              rd_busy;
    logic              rd_done;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int issued = 0;
    int delivered = 0;
    int gaps = 0;
    int cyc = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    logic        prev_stall = 1'b0;
    logic [17:0] prev_word = '0;
    logic        done_pending = 1'b0;

    pkt_read_ctrl #(.ADDR_W(ADDR_W), .PKT_LEN(PKT_LEN)) dut (
        .clk              (clk),
        .rst              (rst),
        .rf_capture_start (rf_capture_start),
        .wr_done          (wr_done),
        .ren              (ren),
        .raddr            (raddr),
        .rdata            (rdata),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .m_sop            (m_sop),
        .m_eop            (m_eop),
        .rd_busy          (rd_busy),
        .rd_done          (rd_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer holds mem[a] = a; unread cycles return noise.
    always @(posedge clk) rdata <= ren ? 16'(raddr) : 16'($urandom);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // {sop, eop, data} of stream word n.
    function automatic logic [17:0] exp_word(input int n);
        int p;
        int o;
        p = n / PKT_WORDS;
        o = n % PKT_WORDS;
        if (o == 0) return {1'b1, 1'b0, 8'hA5, 8'(p)};
        return {1'b0, (o == PKT_LEN), 16'(p * PKT_LEN + o - 1)};
    endfunction

    always @(negedge clk) begin
        if (rst || rf_capture_start) begin
            k = 0;
            issued = 0;
            delivered = 0;
            prev_stall = 1'b0;
            done_pending = 1'b0;
        end else begin
            if (done_pending) begin
                chk("rd_done_rise", {rd_done, rd_busy}, 2'b10);
                done_pending = 1'b0;
            end
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1'b1);
                chk("stall_word", {m_sop, m_eop, m_data}, prev_word);
            end
            if (k > 0 && k < TOTAL && !m_valid) gaps++;
            if (ren) issued++;
            if (m_valid && m_ready) begin
                if (k >= TOTAL) begin
                    chk("extra_word", 1'b1, 1'b0);
                end else begin
                    chk("word", {m_sop, m_eop, m_data}, exp_word(k));
                    if (k == 0) first_cyc = cyc;
                    if (k == TOTAL - 1) begin
                        last_cyc = cyc;
                        done_pending = 1'b1;
                        chk("rd_done_early", rd_done, 1'b0);
                    end
                end
                if (!m_sop) delivered++;
                k++;
            end
            chk("outstanding", (issued - delivered) <= 2, 1'b1);
            prev_stall = m_valid && !m_ready;
            prev_word  = {m_sop, m_eop, m_data};
        end
    end

    initial begin
        int  n;
        bit  stalled;
        bit  hit;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", {ren, m_valid, m_sop, m_eop, rd_busy, rd_done}, 6'b0);
        chk("rst_raddr", raddr, 0);
        chk("rst_data", m_data, 16'h0000);

        @(posedge clk); #1;
        rst = 1'b0;
        m_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_wr_done", {ren, m_valid, rd_busy}, 3'b000);
        end

        // Full readout, ready held high.
        @(posedge clk); #1;
        wr_done = 1'b1;
        gaps = 0;
        @(negedge clk);
        chk("start_idle", m_valid, 1'b0);
        @(negedge clk);
        chk("start_hdr", {m_valid, m_sop, rd_busy}, 3'b111);
        n = 0;
        while (!rd_done && n < TOTAL + 200) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("full_done", rd_done, 1'b1);
        chk("full_count", k, TOTAL);
        chk("full_gaps", gaps, 0);
        chk("full_span", last_cyc - first_cyc + 1, TOTAL);
        chk("full_raddr_wrap", raddr, 0);

        repeat (100) begin
            @(negedge clk);
            chk("done_hold", {ren, m_valid, rd_done, rd_busy}, 4'b0010);
        end

        @(posedge clk); #1;
        rf_capture_start = 1'b1;
        @(negedge clk);
        chk("done_before_clear", rd_done, 1'b1);
        @(posedge clk); #1;
        rf_capture_start = 1'b0;
        @(negedge clk);
        chk("done_clear", {rd_done, rd_busy, m_valid}, 3'b000);

        // Random backpressure, EOP boundary stall, then abort at packet 5 word 100.
        stalled = 1'b0;
        hit = 1'b0;
        n = 0;
        while (!hit && n < 20000) begin
            @(posedge clk); #1;
            n++;
            if (!stalled && k == 2 * PKT_WORDS + PKT_LEN && m_valid) begin
                stalled = 1'b1;
                m_ready = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    chk("eop_hold", {m_valid, m_eop, m_data}, {2'b11, 16'(3 * PKT_LEN - 1)});
                    @(posedge clk); #1;
                end
                m_ready = 1'b1;
            end else if (k == 5 * PKT_WORDS + 1 + 100 && m_valid) begin
                hit = 1'b1;
                m_ready = 1'b1;
                rf_capture_start = 1'b1;
            end else begin
                m_ready = 1'($urandom_range(0, 1));
            end
        end
        chk("boundary_stall_seen", stalled, 1'b1);
        chk("abort_point_reached", hit, 1'b1);
        @(posedge clk); #1;
        rf_capture_start = 1'b0;
        @(negedge clk);
        chk("abort_valid", m_valid, 1'b0);
        chk("abort_raddr", raddr, 0);
        chk("abort_busy", {rd_busy, rd_done}, 2'b00);

        // Restart under random backpressure, then reset mid-DATA.
        hit = 1'b0;
        n = 0;
        while (!hit && n < 20000) begin
            @(posedge clk); #1;
            n++;
            if (k >= 3 * PKT_WORDS && (k % PKT_WORDS) >= 10 && (k % PKT_WORDS) <= 200 && m_valid) begin
                hit = 1'b1;
                chk("restart_in_data", {rd_busy, m_sop}, 2'b10);
                m_ready = 1'b1;
                rst = 1'b1;
            end else begin
                m_ready = 1'($urandom_range(0, 1));
            end
        end
        chk("restart_progress", hit, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_ctl", {ren, m_valid, m_sop, m_eop, rd_busy, rd_done}, 6'b0);
        chk("mid_rst_raddr", raddr, 0);
        chk("mid_rst_data", m_data, 16'h0000);

        wr_done = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_idle", {ren, m_valid, rd_busy, rd_done}, 4'b0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
